// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA scanout timing defaults and RGB332 pixel helpers
package vga_pkg;

    localparam int PIX_DIV_DEF  = 4;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] grn;
        logic [1:0] blu;
    } rgb332_t;

    function automatic rgb332_t rgb332_unpack(input logic [7:0] px);
        return rgb332_t'(px);
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - framebuffer word stream from the fetch master into scanout
interface vga_scanout_if;

    logic [31:0] pix_dat_i;
    logic        pix_vld_i;
    logic        pix_rdy_o;

    modport master (
        output pix_dat_i,
        output pix_vld_i,
        input  pix_rdy_o
    );

    modport slave (
        input  pix_dat_i,
        input  pix_vld_i,
        output pix_rdy_o
    );

endinterface

// File: rtl/vga_word_fifo.sv
// rtl/vga_word_fifo.sv - two-entry word FIFO with synchronous flush
module vga_word_fifo #(
    parameter int W = 32
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing, 4-pixel word unpack and registered pin drive
module vga_scanout
    import vga_pkg::*;
#(
    parameter int PIX_DIV  = PIX_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    vga_scanout_if.slave pix,
    output logic         frame_start_o,
    input  logic         clr_underflow_i,
    output logic         underflow_o,
    output logic         vga_hs_o,
    output logic         vga_vs_o,
    output logic [2:0]   vga_red_o,
    output logic [2:0]   vga_grn_o,
    output logic [1:0]   vga_blu_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(PIX_DIV + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_FS     = VW'(V_ACTIVE - 1);

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick;
    logic          active;
    logic          line_end;
    logic          fs_next;
    logic [23:0]   shreg;
    logic [1:0]    slot_cnt;
    logic [7:0]    px_next;
    logic          need_word;
    rgb332_t       pix_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    assign tick      = (div == DIV_LAST);
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign line_end  = (h_cnt == H_LAST);
    assign fs_next   = tick && line_end && (v_cnt == V_FS);
    assign need_word = tick && active && (slot_cnt == 2'd0);
    assign fifo_pop  = need_word && !fifo_empty;

    // Pushes are refused in the flush clock so no stale word survives into the new frame.
    assign pix.pix_rdy_o = wb_rst_ni && !fifo_full && !frame_start_o;
    assign fifo_push     = pix.pix_vld_i && pix.pix_rdy_o;

    vga_word_fifo #(.W(32)) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .flush     (frame_start_o),
        .push      (fifo_push),
        .din       (pix.pix_dat_i),
        .pop       (fifo_pop),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        px_next = 8'h00;
        if (slot_cnt == 2'd0) begin
            px_next = fifo_empty ? 8'h00 : fifo_dout[31:24];
        end else begin
            px_next = shreg[23:16];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) begin
                h_cnt <= line_end ? '0 : h_cnt + HW'(1);
                if (line_end) begin
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                end
            end
        end
    end

    // An empty FIFO still consumes a 4-pixel slot (black) to keep word alignment on the line.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            shreg    <= '0;
            slot_cnt <= 2'd0;
        end else if (frame_start_o) begin
            shreg    <= '0;
            slot_cnt <= 2'd0;
        end else if (tick && active) begin
            if (slot_cnt == 2'd0) begin
                shreg    <= fifo_empty ? 24'h0 : fifo_dout[23:0];
                slot_cnt <= 2'd3;
            end else begin
                shreg    <= {shreg[15:0], 8'h00};
                slot_cnt <= slot_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vga_hs_o      <= 1'b1;
            vga_vs_o      <= 1'b1;
            pix_q         <= '0;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            frame_start_o <= fs_next;
            if (tick) begin
                vga_hs_o <= !((h_cnt >= H_SS) && (h_cnt < H_SE));
                vga_vs_o <= !((v_cnt >= V_SS) && (v_cnt < V_SE));
                pix_q    <= active ? rgb332_unpack(px_next) : '0;
            end
            if (need_word && fifo_empty) begin
                underflow_o <= 1'b1;
            end else if (clr_underflow_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    assign vga_red_o = pix_q.red;
    assign vga_grn_o = pix_q.grn;
    assign vga_blu_o = pix_q.blu;

endmodule
